// File: rtl/sipo_collector.sv
// Serial-in parallel-out collector: MSB-first frames into a double-buffered output word.
// Optional trailing even-parity bit per frame when SIPO_COLLECTOR_PARITY_EN is defined.
module sipo_collector #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_s,
  input  logic         i_shift,
  input  logic         i_ready,
  output logic [W-1:0] o_p,
  output logic         o_valid,
  output logic         o_overrun
`ifdef SIPO_COLLECTOR_PARITY_EN
  ,
  output logic         o_perr
`endif
);

`ifdef SIPO_COLLECTOR_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif
  localparam int CW = $clog2(F);
  localparam logic [CW-1:0] LAST = CW'(F - 1);

`ifdef SIPO_COLLECTOR_PARITY_EN
  // Even parity over data plus parity bit; a set result flags an error.
  function automatic logic f_parity_err(input logic [F-1:0] frame);
    return ^frame;
  endfunction
`endif

  logic [F-2:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic [F-1:0]  w_frame;
  logic          w_done;
  logic          w_load;

  // Frame as it stands once the bit sampled this edge is included.
  always_comb begin
    w_frame = {r_shift, i_s};
    w_done  = 1'b0;
    w_load  = 1'b0;
    if (i_shift && (r_cnt == LAST)) begin
      w_done = 1'b1;
      w_load = (!o_valid) || i_ready;
    end else begin
      w_done = 1'b0;
      w_load = 1'b0;
    end
  end

  // Shift register and bit counter; both hold across i_shift=0 gaps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= w_frame[F-2:0];
      r_cnt   <= w_done ? '0 : r_cnt + CW'(1);
    end else begin
      r_shift <= r_shift;
      r_cnt   <= r_cnt;
    end
  end

  // Output word register: load when free or being drained, else drop and flag overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_p       <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
`ifdef SIPO_COLLECTOR_PARITY_EN
      o_perr    <= 1'b0;
`endif
    end else if (w_load) begin
`ifdef SIPO_COLLECTOR_PARITY_EN
      o_p       <= w_frame[F-1:1];
      o_perr    <= f_parity_err(w_frame);
`else
      o_p       <= w_frame;
`endif
      o_valid   <= 1'b1;
    end else if (w_done) begin
      o_overrun <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid   <= 1'b0;
    end else begin
      o_valid   <= o_valid;
    end
  end

endmodule

// File: tb/tb_sipo_collector.sv
// Scoreboard bench for sipo_collector: stimulus pushes expected words, a monitor checks each accepted word.
module tb_sipo_collector;
  localparam int W = 4;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_s = 1'b0;
  logic         i_shift = 1'b0;
  logic         i_ready = 1'b0;
  logic [W-1:0] o_p;
  logic         o_valid;
  logic         o_overrun;
`ifdef SIPO_COLLECTOR_PARITY_EN
  logic         o_perr;
`endif

  sipo_collector #(.W(W)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_s       (i_s),
    .i_shift   (i_shift),
    .i_ready   (i_ready),
    .o_p       (o_p),
    .o_valid   (o_valid),
    .o_overrun (o_overrun)
`ifdef SIPO_COLLECTOR_PARITY_EN
    ,
    .o_perr    (o_perr)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] exp_q[$];   // {perr, word}

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake presents one word that must match the queue head.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", int'(o_p), -1);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sb_word", int'(o_p), int'(e[W-1:0]));
`ifdef SIPO_COLLECTOR_PARITY_EN
        check("sb_perr", int'(o_perr), int'(e[W]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    i_shift = 1'b1;
    i_s = b;
    tick();
    i_shift = 1'b0;
    i_s = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic drain();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_p", int'(o_p), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_overrun", int'(o_overrun), 0);
    i_rst = 1'b0;
    tick();

    // 1,0,1,0 with ready low: word appears the cycle after the last bit, held stable
    exp_q.push_back({1'b0, 4'b1010});
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    check("valid_before_last", int'(o_valid), 0);
    send_bit(1'b0, 0);
    check("valid_after_last", int'(o_valid), 1);
    check("p_after_last", int'(o_p), 32'hA);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_p", int'(o_p), 32'hA);
      check("hold_valid", int'(o_valid), 1);
    end
    drain();
    check("valid_cleared", int'(o_valid), 0);

    // 1,1,0,0 with two-cycle gaps
    exp_q.push_back({1'b0, 4'b1100});
    send_word(4'b1100, 2);
    check("gap_valid", int'(o_valid), 1);
    check("gap_p", int'(o_p), 32'hC);
    drain();

    // Accept on the completing edge: new word loads, valid stays high
    exp_q.push_back({1'b0, 4'b1010});
    send_word(4'b1010, 0);
    exp_q.push_back({1'b0, 4'b0101});
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    i_ready = 1'b1;
    send_bit(1'b1, 0);
    i_ready = 1'b0;
    check("bb_valid", int'(o_valid), 1);
    check("bb_p", int'(o_p), 32'h5);
    check("bb_overrun", int'(o_overrun), 0);
    drain();

    // Overrun: second word completes while first is unaccepted
    exp_q.push_back({1'b0, 4'b1010});
    send_word(4'b1010, 0);
    send_word(4'b0110, 0);
    check("ovr_p", int'(o_p), 32'hA);
    check("ovr_flag", int'(o_overrun), 1);
    check("ovr_valid", int'(o_valid), 1);
    drain();
    repeat (3) tick();
    check("ovr_sticky", int'(o_overrun), 1);
    check("ovr_valid_after", int'(o_valid), 0);

    // Partial frame discarded by reset
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    i_rst = 1'b1;
    i_shift = 1'b1;
    i_s = 1'b1;
    tick();
    i_rst = 1'b0;
    i_shift = 1'b0;
    check("rst2_overrun", int'(o_overrun), 0);
    check("rst2_valid", int'(o_valid), 0);
    exp_q.push_back({1'b0, 4'b0011});
    send_word(4'b0011, 0);
    check("rst2_p", int'(o_p), 32'h3);
    check("rst2_valid_after", int'(o_valid), 1);
    drain();

`ifdef SIPO_COLLECTOR_PARITY_EN
    // Good parity then bad parity; both words delivered
    exp_q.push_back({1'b0, 4'b1010});
    send_word(4'b1010, 0);
    send_bit(1'b0, 0);
    check("par_good", int'(o_perr), 0);
    drain();
    exp_q.push_back({1'b1, 4'b1010});
    send_word(4'b1010, 0);
    send_bit(1'b1, 0);
    check("par_bad", int'(o_perr), 1);
    check("par_bad_p", int'(o_p), 32'hA);
    drain();
`endif

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
